// File: rtl/nios_mul_combine_pkg.sv
// Shared constants for the multiplier combine stage: default pipeline
// split, destination index width and the half-word width used to place
// the cross term.
package nios_mul_combine_pkg;

    localparam int PIPE_SPLIT_DEF = 1;
    localparam int DST_W_DEF      = 5;
    localparam int HALF_W         = 16;
    localparam int WORD_W         = 2 * HALF_W;

endpackage : nios_mul_combine_pkg

// File: rtl/nios_mul_combine_stage.sv
// Generic valid/ready register slice. It loads whenever it is empty or its
// content is being taken downstream. Flush clears the valid bit only; the
// data register keeps its value because it is don't-care while invalid.
module nios_mul_combine_stage
    import nios_mul_combine_pkg::*;
#(
    parameter int DATA_W = WORD_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready
);

    logic              valid_r;
    logic [DATA_W-1:0] data_r;
    logic              ready_s;

    // Slice can take new data when empty or when its content leaves this cycle.
    always_comb begin
        ready_s = ~valid_r | out_ready;
    end

    // Valid/data register with reset, flush and hold-on-stall behaviour.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_r <= 1'b0;
            data_r  <= {DATA_W{1'b0}};
        end else if (flush) begin
            valid_r <= 1'b0;
            data_r  <= data_r;
        end else if (ready_s) begin
            valid_r <= in_valid;
            if (in_valid) begin
                data_r <= in_data;
            end else begin
                data_r <= data_r;
            end
        end else begin
            valid_r <= valid_r;
            data_r  <= data_r;
        end
    end

    assign in_ready  = ready_s;
    assign out_valid = valid_r;
    assign out_data  = data_r;

endmodule : nios_mul_combine_stage

// File: rtl/nios_mul_combine.sv
// Combines the three 16x16 partial products into the low 32 bits of a
// 32x32 product. Only the low halves of the cross products matter because
// they are shifted up by 16 and everything above bit 31 is discarded, so
// the result is the same for signed and unsigned operands.
module nios_mul_combine
    import nios_mul_combine_pkg::*;
#(
    parameter int PIPE_SPLIT = PIPE_SPLIT_DEF,
    parameter int DST_W      = DST_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      M_mul_cell_p1,
    input  logic [31:0]      M_mul_cell_p2,
    input  logic [31:0]      M_mul_cell_p3,
    input  logic             M_mul_valid,
    input  logic [DST_W-1:0] M_mul_dst,
    output logic             M_mul_ready,
    input  logic             A_en,
    input  logic             A_flush,
    output logic [31:0]      A_mul_result,
    output logic             A_mul_valid,
    output logic [DST_W-1:0] A_mul_dst
);

    localparam int S1_W = WORD_W + HALF_W + DST_W;
    localparam int S2_W = WORD_W + DST_W;

    logic [HALF_W-1:0] in_cross_s;
    logic              s2_in_valid_s;
    logic [S2_W-1:0]   s2_in_data_s;
    logic              s2_ready_s;
    logic              s2_valid_s;
    logic [S2_W-1:0]   s2_data_s;
    logic              unused_s;

    // Upper halves of the cross products fall above bit 31 of the result.
    assign unused_s = ^{M_mul_cell_p2[31:16], M_mul_cell_p3[31:16]};

    // Cross-term sum of the low halves; its carry out lies above bit 31.
    always_comb begin
        in_cross_s = M_mul_cell_p2[HALF_W-1:0] + M_mul_cell_p3[HALF_W-1:0];
    end

    generate
        if (PIPE_SPLIT != 0) begin : g_split
            logic              s1_ready_s;
            logic              s1_valid_s;
            logic [S1_W-1:0]   s1_data_s;
            logic [WORD_W-1:0] s1_p1_s;
            logic [HALF_W-1:0] s1_cross_s;
            logic [DST_W-1:0]  s1_dst_s;

            nios_mul_combine_stage #(
                .DATA_W (S1_W)
            ) u_s1 (
                .clk       (clk),
                .reset     (reset),
                .flush     (A_flush),
                .in_valid  (M_mul_valid),
                .in_data   ({M_mul_cell_p1, in_cross_s, M_mul_dst}),
                .in_ready  (s1_ready_s),
                .out_valid (s1_valid_s),
                .out_data  (s1_data_s),
                .out_ready (s2_ready_s)
            );

            // Unpack the first-stage word and form the final sum from it.
            always_comb begin
                s1_p1_s       = s1_data_s[S1_W-1 -: WORD_W];
                s1_cross_s    = s1_data_s[DST_W +: HALF_W];
                s1_dst_s      = s1_data_s[DST_W-1:0];
                s2_in_valid_s = s1_valid_s;
                s2_in_data_s  = {s1_p1_s + {s1_cross_s, {HALF_W{1'b0}}}, s1_dst_s};
            end

            assign M_mul_ready = s1_ready_s;
        end else begin : g_single
            // Single stage: the final sum is formed straight from the inputs.
            always_comb begin
                s2_in_valid_s = M_mul_valid;
                s2_in_data_s  = {M_mul_cell_p1 + {in_cross_s, {HALF_W{1'b0}}}, M_mul_dst};
            end

            assign M_mul_ready = s2_ready_s;
        end
    endgenerate

    nios_mul_combine_stage #(
        .DATA_W (S2_W)
    ) u_s2 (
        .clk       (clk),
        .reset     (reset),
        .flush     (A_flush),
        .in_valid  (s2_in_valid_s),
        .in_data   (s2_in_data_s),
        .in_ready  (s2_ready_s),
        .out_valid (s2_valid_s),
        .out_data  (s2_data_s),
        .out_ready (A_en)
    );

    assign A_mul_valid  = s2_valid_s;
    assign A_mul_result = s2_data_s[S2_W-1 -: WORD_W];
    assign A_mul_dst    = s2_data_s[DST_W-1:0];

endmodule : nios_mul_combine

// File: tb/tb_nios_mul_combine.sv
// Directed bench for nios_mul_combine: a two-stage instance driven through
// a scoreboard and a single-stage instance checked cycle by cycle.
module tb_nios_mul_combine;

    localparam int DST_W = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Two-stage instance
    logic             reset;
    logic [31:0]      src1, src2;
    logic [31:0]      p1, p2, p3;
    logic             m_valid;
    logic [DST_W-1:0] dst;
    logic             a_en, a_flush;
    logic             m_ready, a_valid;
    logic [31:0]      a_res;
    logic [DST_W-1:0] a_dst;

    // Single-stage instance
    logic [31:0]      s0_src1, s0_src2;
    logic [31:0]      s0_p1, s0_p2, s0_p3;
    logic             s0_valid;
    logic [DST_W-1:0] s0_dst;
    logic             s0_en, s0_flush;
    logic             s0_ready, s0_ovalid;
    logic [31:0]      s0_res;
    logic [DST_W-1:0] s0_odst;

    // Partial products as the 16x16 cell would produce them
    assign p1    = {16'h0000, src1[15:0]}  * {16'h0000, src2[15:0]};
    assign p2    = {16'h0000, src1[15:0]}  * {16'h0000, src2[31:16]};
    assign p3    = {16'h0000, src1[31:16]} * {16'h0000, src2[15:0]};
    assign s0_p1 = {16'h0000, s0_src1[15:0]}  * {16'h0000, s0_src2[15:0]};
    assign s0_p2 = {16'h0000, s0_src1[15:0]}  * {16'h0000, s0_src2[31:16]};
    assign s0_p3 = {16'h0000, s0_src1[31:16]} * {16'h0000, s0_src2[15:0]};

    nios_mul_combine #(.PIPE_SPLIT(1), .DST_W(DST_W)) dut (
        .clk(clk), .reset(reset),
        .M_mul_cell_p1(p1), .M_mul_cell_p2(p2), .M_mul_cell_p3(p3),
        .M_mul_valid(m_valid), .M_mul_dst(dst), .M_mul_ready(m_ready),
        .A_en(a_en), .A_flush(a_flush),
        .A_mul_result(a_res), .A_mul_valid(a_valid), .A_mul_dst(a_dst)
    );

    nios_mul_combine #(.PIPE_SPLIT(0), .DST_W(DST_W)) dut0 (
        .clk(clk), .reset(reset),
        .M_mul_cell_p1(s0_p1), .M_mul_cell_p2(s0_p2), .M_mul_cell_p3(s0_p3),
        .M_mul_valid(s0_valid), .M_mul_dst(s0_dst), .M_mul_ready(s0_ready),
        .A_en(s0_en), .A_flush(s0_flush),
        .A_mul_result(s0_res), .A_mul_valid(s0_ovalid), .A_mul_dst(s0_odst)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [36:0] sb[$];
    logic [36:0] exp_e;

    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] f;
        f = {32'h0000_0000, a} * {32'h0000_0000, b};
        return f[31:0];
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one product to the two-stage instance and wait (bounded) for its capture edge.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [DST_W-1:0] d);
        bit ok;
        ok      = 1'b0;
        src1    = a;
        src2    = b;
        dst     = d;
        m_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (m_ready) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        check("send_accept", 64'(ok), 64'(1'b1));
        step();
    endtask

    // Scoreboard: push on input transfer, pop and compare on output transfer.
    always @(negedge clk) begin
        if (reset || a_flush) begin
            sb.delete();
        end else begin
            if (a_valid && a_en) begin
                if (sb.size() == 0) begin
                    check("sb_spurious", 64'(a_valid), 64'(1'b0));
                end else begin
                    exp_e = sb.pop_front();
                    check("sb_out", 64'({a_res, a_dst}), 64'(exp_e));
                end
            end
            if (m_valid && m_ready) begin
                sb.push_back({ref_mul(src1, src2), dst});
            end
        end
    end

    logic [31:0]      t_a [4];
    logic [31:0]      t_b [4];
    logic [31:0]      prev_exp;
    logic [DST_W-1:0] prev_dst;

    initial begin
        t_a = '{32'h0003_0002, 32'hFFFF_FFFF, 32'h1234_5678, 32'h8000_0001};
        t_b = '{32'h0005_0004, 32'hFFFF_FFFF, 32'h9ABC_DEF0, 32'h7FFF_FFFF};
        reset = 1'b1; src1 = 32'h0; src2 = 32'h0; m_valid = 1'b0; dst = 5'd0;
        a_en = 1'b0; a_flush = 1'b0;
        s0_src1 = 32'h0; s0_src2 = 32'h0; s0_valid = 1'b0; s0_dst = 5'd0;
        s0_en = 1'b1; s0_flush = 1'b0;
        prev_exp = 32'h0; prev_dst = 5'd0;
        step();
        step();
        reset = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_valid", 64'(a_valid), 64'(1'b0));
        check("rst_result", 64'(a_res), 64'(32'h0));
        check("rst_dst", 64'(a_dst), 64'(5'd0));
        check("rst_ready", 64'(m_ready), 64'(1'b1));
        check("rst0_valid", 64'(s0_ovalid), 64'(1'b0));
        step();

        // 1: basic product and two-edge latency
        a_en = 1'b1;
        send(32'h0003_0002, 32'h0005_0004, 5'd7);
        m_valid = 1'b0;
        @(negedge clk);
        check("lat_not_yet", 64'(a_valid), 64'(1'b0));
        step();
        @(negedge clk);
        check("basic_valid", 64'(a_valid), 64'(1'b1));
        check("basic_result", 64'(a_res), 64'(32'h0016_0008));
        check("basic_dst", 64'(a_dst), 64'(5'd7));
        step();

        // 2: cross-term carry discarded
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3);
        m_valid = 1'b0;
        step();
        @(negedge clk);
        check("carry_result", 64'(a_res), 64'(32'h0000_0001));
        step();
        step();

        // 3: back-pressure, four products through a stalled pipe
        a_en = 1'b0;
        send(32'h0000_0011, 32'h0000_0013, 5'd1);
        send(32'h0002_0001, 32'h0001_0003, 5'd2);
        src1 = 32'h1234_5678; src2 = 32'h0000_0100; dst = 5'd3;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_ready_low", 64'(m_ready), 64'(1'b0));
            check("bp_hold_dst", 64'(a_dst), 64'(5'd1));
            step();
        end
        a_en = 1'b1;
        send(32'h1234_5678, 32'h0000_0100, 5'd3);
        send(32'hDEAD_BEEF, 32'hCAFE_F00D, 5'd4);
        m_valid = 1'b0;
        repeat (6) step();
        @(negedge clk);
        check("bp_drained", 64'(sb.size()), 64'(0));
        check("bp_idle", 64'(a_valid), 64'(1'b0));
        step();

        // 4: flush with a same-cycle input offer
        a_en = 1'b0;
        send(32'h0000_0101, 32'h0000_0202, 5'd4);
        send(32'h0000_0303, 32'h0000_0404, 5'd5);
        src1 = 32'h0000_0505; src2 = 32'h0000_0606; dst = 5'd6;
        m_valid = 1'b1; a_flush = 1'b1; a_en = 1'b1;
        step();
        a_flush = 1'b0; m_valid = 1'b0;
        @(negedge clk);
        check("flush_valid", 64'(a_valid), 64'(1'b0));
        step();
        @(negedge clk);
        check("flush_no_ghost", 64'(a_valid), 64'(1'b0));
        step();
        send(32'h0007_0009, 32'h000B_000D, 5'd8);
        m_valid = 1'b0;
        step();
        @(negedge clk);
        check("post_flush_valid", 64'(a_valid), 64'(1'b1));
        check("post_flush_dst", 64'(a_dst), 64'(5'd8));
        check("post_flush_res", 64'(a_res), 64'(ref_mul(32'h0007_0009, 32'h000B_000D)));
        step();

        // 5: reset while stalled and full
        a_en = 1'b0;
        send(32'h0000_0021, 32'h0000_0022, 5'd10);
        send(32'h0000_0023, 32'h0000_0024, 5'd11);
        src1 = 32'h0000_0025; src2 = 32'h0000_0026; dst = 5'd12;
        reset = 1'b1;
        step();
        reset = 1'b0; m_valid = 1'b0;
        @(negedge clk);
        check("mrst_valid", 64'(a_valid), 64'(1'b0));
        check("mrst_result", 64'(a_res), 64'(32'h0));
        check("mrst_dst", 64'(a_dst), 64'(5'd0));
        check("mrst_ready", 64'(m_ready), 64'(1'b1));
        a_en = 1'b1;
        step();
        step();
        @(negedge clk);
        check("mrst_empty", 64'(a_valid), 64'(1'b0));
        step();

        // 6: single-stage instance, back-to-back with one-edge latency
        for (int i = 0; i < 4; i++) begin
            s0_src1 = t_a[i]; s0_src2 = t_b[i]; s0_dst = 5'(i + 16); s0_valid = 1'b1;
            @(negedge clk);
            check("ps0_ready", 64'(s0_ready), 64'(1'b1));
            if (i > 0) begin
                check("ps0_valid", 64'(s0_ovalid), 64'(1'b1));
                check("ps0_result", 64'(s0_res), 64'(prev_exp));
                check("ps0_dst", 64'(s0_odst), 64'(prev_dst));
            end
            prev_exp = ref_mul(t_a[i], t_b[i]);
            prev_dst = 5'(i + 16);
            step();
        end
        s0_valid = 1'b0;
        @(negedge clk);
        check("ps0_last_valid", 64'(s0_ovalid), 64'(1'b1));
        check("ps0_last_result", 64'(s0_res), 64'(prev_exp));
        check("ps0_last_dst", 64'(s0_odst), 64'(prev_dst));
        step();
        @(negedge clk);
        check("ps0_drained", 64'(s0_ovalid), 64'(1'b0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_nios_mul_combine
